result_display_driver: RTL and testbench

- Downstream consumer of the processor's 16-bit result bus.
- Latches the value on a load strobe and shows it as four hex digits on a common-anode, time-multiplexed 7-segment display.
- Generates the digit scan with an internal prescaler and blanks briefly between digits to stop ghosting.
- Sits between the processor's result output and the board display pins.

---
 rtl/result_display_driver_if.sv | 20 ++
 rtl/result_display_driver.sv | 118 +++++++++++
 tb/tb_result_display_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/result_display_driver_if.sv
// Bus bundle between the processor result output and the display driver.
// master: drives data_in/load, observes the display pins; slave: the driver.
interface result_display_driver_if;
    logic [15:0] data_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] shown;

    modport master (
        output data_in, load,
        input  seg, dp, an, shown
    );

    modport slave (
        input  data_in, load,
        output seg, dp, an, shown
    );
endinterface

// File: rtl/result_display_driver.sv
// Latches the 16-bit result and scans it as 4 hex digits on a common-anode,
// time-multiplexed 7-segment display with a short blank at each slot start.
// Ports: clk, rst (async, active-low), bus (slave): data_in, load in;
//        seg {g,f,e,d,c,b,a}, dp, an (an[0] rightmost), shown out; all active-low pins.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits 3..1 and
// light digit-0 dp whenever any digit is suppressed.
module result_display_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                     clk,
    input  logic                     rst,
    result_display_driver_if.slave   bus
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK = PW'(BLANK_CYCLES);

    logic [15:0]   shown_q, shown_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    nib;
    logic          digit_off;
    logic          dp_lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        shown_d = bus.load ? bus.data_in : shown_q;

        if (presc_q == LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + 1'b1;
            idx_d   = idx_q;
        end

        unique case (idx_q)
            2'd0:    nib = shown_q[3:0];
            2'd1:    nib = shown_q[7:4];
            2'd2:    nib = shown_q[11:8];
            default: nib = shown_q[15:12];
        endcase

        digit_off = 1'b0;
        dp_lit    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every higher digit are 0.
        unique case (idx_q)
            2'd3:    digit_off = (shown_q[15:12] == 4'h0);
            2'd2:    digit_off = (shown_q[15:8] == 8'h0);
            2'd1:    digit_off = (shown_q[15:4] == 12'h0);
            default: digit_off = 1'b0;
        endcase
        // Digit 3 is suppressed exactly when some digit is suppressed.
        dp_lit = (idx_q == 2'd0) && (shown_q[15:12] == 4'h0);
`else
`endif

        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if ((presc_q >= BLANK) && !digit_off) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(nib);
            dp_d  = ~dp_lit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shown_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            shown_q <= shown_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;
    assign bus.shown = shown_q;
endmodule

// File: tb/tb_result_display_driver.sv
// Scoreboard bench for result_display_driver: stimulus queues per-cycle
// expected pins, a monitor pops and compares after every clock edge.
module tb_result_display_driver;
    localparam int RD = 8;
    localparam int BC = 2;

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] shown;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_display_driver_if bus ();

    result_display_driver #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic [15:0] sh_m = 16'h0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    endtask

    // Expected pins after the edge that ends cycle cyc_pre
    // (prescaler/index derived from edges since release).
    function automatic exp_t expect_out(input int cyc_pre,
                                        input logic [15:0] sh,
                                        input logic [15:0] sh_nxt);
        exp_t e;
        int p;
        int i;
        logic [3:0] nib;
        bit off;
        bit dpl;
        p = cyc_pre % RD;
        i = (cyc_pre / RD) % 4;
        nib = sh[4*i +: 4];
        off = 1'b0;
        dpl = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        off = (i > 0) && ((sh >> (4*i)) == 16'h0);
        dpl = (i == 0) && (sh[15:12] == 4'h0);
`endif
        e.an = 4'hF;
        e.seg = 7'h7F;
        e.dp = 1'b1;
        e.shown = sh_nxt;
        if (p >= BC && !off) begin
            e.an = 4'hF ^ (4'h1 << i);
            e.seg = SEG[nib];
            e.dp = ~dpl;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic ld, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.load = ld;
        bus.data_in = d;
        if (!r) begin
            e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.shown = 16'h0;
        end else begin
            e = expect_out(cyc, sh_m, ld ? d : sh_m);
        end
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            cyc++;
            if (ld) sh_m = d;
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an", 32'(bus.an), 32'(e.an));
            chk("seg", 32'(bus.seg), 32'(e.seg));
            chk("dp", 32'(bus.dp), 32'(e.dp));
            chk("shown", 32'(bus.shown), 32'(e.shown));
        end
        chk("an_single_low", 32'($countones(~bus.an) <= 1), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [15:0] vecs [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [15:0] lzv  [3] = '{16'h0040, 16'h0000, 16'h8000};

    initial begin
        rst = 1'b0;
        bus.load = 1'b0;
        bus.data_in = 16'h0;

        repeat (5) step(1'b0, 1'b1, 16'hFFFF);

        step(1'b1, 1'b1, 16'h1234);
        repeat (39) step(1'b1, 1'b0, 16'h0);

        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, vecs[k]);
            repeat (31) step(1'b1, 1'b0, 16'h0);
        end

        step(1'b1, 1'b1, 16'hAAAA);
        while (cyc % 32 != 12) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h5555);
        while (cyc % RD != RD - 1) step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h1234);
        repeat (16) step(1'b1, 1'b0, 16'h0);

        while (cyc % RD != 5) step(1'b1, 1'b0, 16'h0);
        #2 rst = 1'b0;
        #1;
        chk("async_an", 32'(bus.an), 32'hF);
        chk("async_seg", 32'(bus.seg), 32'h7F);
        chk("async_dp", 32'(bus.dp), 32'h1);
        chk("async_shown", 32'(bus.shown), 32'h0);
        cyc = 0;
        sh_m = 16'h0;
        repeat (2) step(1'b0, 1'b0, 16'h0);
        repeat (40) step(1'b1, 1'b0, 16'h0);

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, lzv[k]);
            repeat (31) step(1'b1, 1'b0, 16'h0);
        end

        @(negedge clk);
        bus.load = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
